// File: rtl/seq_divider.sv
// Multicycle signed divider: restoring division on operand magnitudes, one bit per clock,
// with a final sign-fix cycle before the quotient/remainder land on lo/hi.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             sgn_quo_q, sgn_quo_d;
    logic             sgn_rem_q, sgn_rem_d;
    logic             dz_q, dz_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] a_mag, b_mag, diff;
    logic [WIDTH:0]   shifted;
    logic             ge;

    // Magnitudes fit unsigned WIDTH bits, including the most negative value.
    assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

    // The shifted partial remainder needs one extra bit before the compare.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign diff    = shifted[WIDTH-1:0] - dvs_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        dz_d      = dz_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        dz_d      = 1'b0;
                        rem_d     = '0;
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                        sgn_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sgn_rem_d = dividend[WIDTH-1];
                        cnt_d     = '0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (ge) begin
                    rem_d = diff;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                lo_d    = sgn_quo_q ? -quo_q : quo_q;
                hi_d    = sgn_rem_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            dz_q      <= dz_d;
            cnt_q     <= cnt_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;
    assign busy     = (state_q == CALC) || (state_q == FIX);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: per-cycle comparison against a timing-aware arithmetic model,
// plus literal checks of known quotient/remainder pairs.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend, divisor;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Signed divide in 64 bits so the most-negative / -1 case wraps instead of trapping.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Model: a request is taken when the unit is idle, i.e. two edges past the last done.
    // A real division shows its result and done 33 edges after acceptance; a zero divisor
    // shows done on the accepting edge itself with hi/lo untouched.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_dz = 1'b0, pend = 1'b0;
    int          done_c = -10;

    initial begin
        logic [63:0] r;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                m_hi = '0; m_lo = '0; m_dz = 1'b0; pend = 1'b0; done_c = -10;
            end else if (start && cyc >= done_c + 2) begin
                if (divisor == 32'd0) begin
                    m_dz = 1'b1;
                    done_c = cyc;
                end else begin
                    r = ref_div(dividend, divisor);
                    p_hi = r[63:32];
                    p_lo = r[31:0];
                    m_dz = 1'b0;
                    pend = 1'b1;
                    done_c = cyc + 33;
                end
            end
            if (reset && pend && cyc == done_c) begin
                m_hi = p_hi; m_lo = p_lo; pend = 1'b0;
            end
            #1;
            chk("busy", {31'd0, busy}, {31'd0, pend});
            chk("done", {31'd0, done}, {31'd0, (reset && cyc == done_c)});
            chk("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            if (done) done_seen++;
        end
    end

    task automatic wait_done(input string nm, output int lat, output bit ok);
        int k, n;
        k = cyc;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok  = done;
        lat = cyc - k;
        if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic div_lit(input logic [31:0] a, input logic [31:0] b, input logic [31:0] el,
                           input logic [31:0] eh, input logic edz, input int elat, input string nm);
        int lat;
        bit ok;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nm, lat, ok);
        if (ok) begin
            chk({nm, "_lat"}, lat, elat);
            chk({nm, "_lo"}, lo, el);
            chk({nm, "_hi"}, hi, eh);
            chk({nm, "_dz"}, {31'd0, div_zero}, {31'd0, edz});
        end
        @(negedge clk);
    endtask

    task automatic go_rand(input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            start = ($urandom_range(0, 9) == 0);
            dividend = $urandom;
            divisor = $urandom;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) chk("rand_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int k, d0;
        logic [31:0] a, b;
        reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;

        div_lit(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33, "p7_2");
        div_lit(-32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, "m7_2");
        div_lit(32'd7, -32'sd2, 32'hFFFFFFFD, 32'd1, 1'b0, 33, "p7_m2");
        div_lit(-32'sd7, -32'sd2, 32'd3, 32'hFFFFFFFF, 1'b0, 33, "m7_m2");
        div_lit(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33, "ovf");
        div_lit(32'h80000000, 32'd1, 32'h80000000, 32'd0, 1'b0, 33, "min_1");
        div_lit(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33, "pre_z");
        div_lit(32'd5, 32'd0, 32'd3, 32'd1, 1'b1, 0, "z5_0");
        div_lit(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, "p9_3");

        // Restarts during CALC and during DONE must be ignored.
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; k = cyc;
        while (cyc != k + 4) @(negedge clk);
        dividend = 32'd1; divisor = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc != k + 33) @(negedge clk);
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_lo", lo, 32'd14);
        chk("ign_hi", hi, 32'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = done_seen;
        repeat (40) @(negedge clk);
        chk("ign_no_done", done_seen, d0);
        chk("ign_lo_hold", lo, 32'd14);

        // Reset in the middle of a division.
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        d0 = done_seen;
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_hi", hi, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_seen, d0);
        div_lit(32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 33, "p10_3");

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'h80000000;
                3, 4: b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 20))
                                                       : -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            go_rand(a, b);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
